// File: rtl/formatter_parser.sv
// Reassembles formatted FIFO words into parallel track records and end-of-event records.
// Define FORMATTER_PARSER_CHECK_EN to enable EP framing checks, ERR_SHORT/ERR_LONG and resynchronisation.
module formatter_parser #(
  parameter int WORDS_PER_TRACK = 7,
  parameter int NTRK_W          = 8
) (
  input  logic                         CLOCK,
  input  logic                         RESET_N,
  input  logic [22:0]                  IN_FIFO_DATA,
  input  logic                         IN_FIFO_EMPTY,
  output logic                         IN_FIFO_RE,
  output logic [21*WORDS_PER_TRACK-1:0] REC_DATA,
  output logic                         REC_EE,
  output logic [NTRK_W-1:0]            REC_NTRK,
  output logic                         REC_VALID,
  input  logic                         REC_READY,
  output logic                         ERR_SHORT,
  output logic                         ERR_LONG
);

  localparam int REC_W = 21 * WORDS_PER_TRACK;
  localparam int WC_W  = (WORDS_PER_TRACK > 1) ? $clog2(WORDS_PER_TRACK) : 1;
  localparam logic [WC_W-1:0] LAST = WC_W'(WORDS_PER_TRACK - 1);

`ifdef FORMATTER_PARSER_CHECK_EN
  typedef enum logic {COLLECT, RESYNC} state_t;
  state_t state;
`endif

  logic              stall;
  logic              rd_pending;
  logic              skid_full;
  logic [22:0]       skid_q;
  logic [22:0]       word;
  logic              have_word;
  logic [WC_W-1:0]   wcnt;
  logic [NTRK_W-1:0] ntrk;
  logic [REC_W-1:0]  asm_q;
  logic [REC_W-1:0]  track_rec;

  assign stall      = REC_VALID && !REC_READY;
  assign IN_FIFO_RE = RESET_N && !IN_FIFO_EMPTY && !stall && !skid_full;
  // A parked skid word always takes precedence over the FIFO bus.
  assign word       = skid_full ? skid_q : IN_FIFO_DATA;
  assign have_word  = skid_full || rd_pending;

  always_comb begin
    track_rec = asm_q;
    track_rec[REC_W-1 -: 21] = word[20:0];
  end

`ifndef FORMATTER_PARSER_CHECK_EN
  assign ERR_SHORT = 1'b0;
  assign ERR_LONG  = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_pending <= 1'b0;
      skid_full  <= 1'b0;
      skid_q     <= '0;
      wcnt       <= '0;
      ntrk       <= '0;
      asm_q      <= '0;
      REC_DATA   <= '0;
      REC_EE     <= 1'b0;
      REC_NTRK   <= '0;
      REC_VALID  <= 1'b0;
`ifdef FORMATTER_PARSER_CHECK_EN
      state      <= COLLECT;
      ERR_SHORT  <= 1'b0;
      ERR_LONG   <= 1'b0;
`endif
    end else begin
      rd_pending <= IN_FIFO_RE;
`ifdef FORMATTER_PARSER_CHECK_EN
      ERR_SHORT  <= 1'b0;
      ERR_LONG   <= 1'b0;
`endif
      if (REC_VALID && REC_READY) REC_VALID <= 1'b0;

      if (stall) begin
        if (rd_pending) begin
          skid_q    <= IN_FIFO_DATA;
          skid_full <= 1'b1;
        end
      end else if (have_word) begin
        skid_full <= 1'b0;
        if (word[22]) begin
          REC_DATA  <= REC_W'(word[20:0]);
          REC_EE    <= 1'b1;
          REC_NTRK  <= ntrk;
          REC_VALID <= 1'b1;
          ntrk      <= '0;
          wcnt      <= '0;
`ifdef FORMATTER_PARSER_CHECK_EN
          if (wcnt != '0) ERR_SHORT <= 1'b1;
          state <= COLLECT;
`endif
        end
`ifdef FORMATTER_PARSER_CHECK_EN
        else if (state == RESYNC) begin
          if (word[21]) state <= COLLECT;
        end else if (wcnt != LAST) begin
          if (word[21]) begin
            ERR_SHORT <= 1'b1;
            wcnt      <= '0;
          end else begin
            asm_q[21*int'(wcnt) +: 21] <= word[20:0];
            wcnt <= wcnt + 1'b1;
          end
        end else if (word[21]) begin
          REC_DATA  <= track_rec;
          REC_EE    <= 1'b0;
          REC_NTRK  <= '0;
          REC_VALID <= 1'b1;
          if (ntrk != '1) ntrk <= ntrk + 1'b1;
          wcnt <= '0;
        end else begin
          ERR_LONG <= 1'b1;
          wcnt     <= '0;
          state    <= RESYNC;
        end
`else
        else if (wcnt != LAST) begin
          asm_q[21*int'(wcnt) +: 21] <= word[20:0];
          wcnt <= wcnt + 1'b1;
        end else begin
          REC_DATA  <= track_rec;
          REC_EE    <= 1'b0;
          REC_NTRK  <= '0;
          REC_VALID <= 1'b1;
          if (ntrk != '1) ntrk <= ntrk + 1'b1;
          wcnt <= '0;
        end
`endif
      end
    end
  end

endmodule
